// File: rtl/tb_axi_lat_pkg.sv
// Shared constants and default AXI4 channel typedefs for the latency injector.
// Channel structs follow the field layout of the axi typedef macros.
package tb_axi_lat_pkg;

  localparam int unsigned DefaultLatency   = 8;
  localparam int unsigned DefaultFifoDepth = 8;
  localparam int unsigned StatsCntWidth    = 32;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;

  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } axi_aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } axi_w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } axi_b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } axi_ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_rsp_t;

  function automatic int unsigned lat_age_width(input int unsigned lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/tb_axi_lat_fifo.sv
// Ageing FIFO: an entry becomes visible at the head only once it has
// aged Latency cycles; no bypass, push refused while full.
module tb_axi_lat_fifo
  import tb_axi_lat_pkg::*;
#(
  parameter int unsigned Latency = DefaultLatency,
  parameter int unsigned Depth   = DefaultFifoDepth,
  parameter type         data_t  = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  input  data_t in_data_i,
  output logic  out_valid_o,
  input  logic  out_ready_i,
  output data_t out_data_o
);

  localparam int unsigned AgeW = lat_age_width(Latency);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  localparam logic [AgeW-1:0] AgeMax  = AgeW'(Latency);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  data_t           r_data [Depth];
  logic [AgeW-1:0] r_age  [Depth];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_cnt;
  logic            w_push, w_pop;

  assign in_ready_o  = (r_cnt != CntFull);
  assign w_push      = in_valid_i && in_ready_o;
  assign out_valid_o = (r_cnt != '0) && (r_age[r_rptr] == AgeMax);
  assign out_data_o  = r_data[r_rptr];
  assign w_pop       = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) r_data[r_wptr] <= in_data_i;
  end

  // The acceptance cycle itself counts as age 0, so the stored age starts
  // at 1; the head is then released exactly Latency cycles after acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) r_age[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (w_push && (r_wptr == PtrW'(i))) r_age[i] <= AgeW'(1);
        else if (r_age[i] != AgeMax)        r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PtrLast) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/tb_axi_lat_inject.sv
// AXI4 address-channel latency injector between occamy_top and tb_memory_axi.
// Define TB_AXI_LAT_STATS_EN to build the AW/AR/stall statistics counters.
module tb_axi_lat_inject
  import tb_axi_lat_pkg::*;
#(
  parameter int unsigned Latency   = DefaultLatency,
  parameter int unsigned FifoDepth = DefaultFifoDepth,
  parameter type         aw_chan_t = axi_aw_chan_t,
  parameter type         ar_chan_t = axi_ar_chan_t,
  parameter type         req_t     = axi_req_t,
  parameter type         rsp_t     = axi_rsp_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  req_t                     slv_req_i,
  output rsp_t                     slv_rsp_o,
  output req_t                     mst_req_o,
  input  rsp_t                     mst_rsp_i,
  output logic [StatsCntWidth-1:0] aw_cnt_o,
  output logic [StatsCntWidth-1:0] ar_cnt_o,
  output logic [StatsCntWidth-1:0] stall_cnt_o
);

  if ((Latency < 1) || (Latency > 1023)) begin : g_bad_latency
    $fatal(1, "tb_axi_lat_inject: Latency must be within 1..1023");
  end
  if (FifoDepth < 2) begin : g_bad_depth
    $fatal(1, "tb_axi_lat_inject: FifoDepth must be at least 2");
  end

  logic     w_aw_ready, w_aw_valid, w_ar_ready, w_ar_valid;
  aw_chan_t w_aw;
  ar_chan_t w_ar;

  tb_axi_lat_fifo #(
    .Latency (Latency),
    .Depth   (FifoDepth),
    .data_t  (aw_chan_t)
  ) u_aw_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (slv_req_i.aw_valid),
    .in_ready_o  (w_aw_ready),
    .in_data_i   (slv_req_i.aw),
    .out_valid_o (w_aw_valid),
    .out_ready_i (mst_rsp_i.aw_ready),
    .out_data_o  (w_aw)
  );

  tb_axi_lat_fifo #(
    .Latency (Latency),
    .Depth   (FifoDepth),
    .data_t  (ar_chan_t)
  ) u_ar_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (slv_req_i.ar_valid),
    .in_ready_o  (w_ar_ready),
    .in_data_i   (slv_req_i.ar),
    .out_valid_o (w_ar_valid),
    .out_ready_i (mst_rsp_i.ar_ready),
    .out_data_o  (w_ar)
  );

  // W, B and R ride straight through; only AW/AR are replaced by the FIFO heads.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw       = w_aw;
    mst_req_o.aw_valid = w_aw_valid;
    mst_req_o.ar       = w_ar;
    mst_req_o.ar_valid = w_ar_valid;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.aw_ready = w_aw_ready;
    slv_rsp_o.ar_ready = w_ar_ready;
  end

`ifdef TB_AXI_LAT_STATS_EN
  logic [StatsCntWidth-1:0] r_aw_cnt, r_ar_cnt, r_stall_cnt;
  logic                     w_aw_push, w_ar_push, w_stall;

  assign w_aw_push = slv_req_i.aw_valid && w_aw_ready;
  assign w_ar_push = slv_req_i.ar_valid && w_ar_ready;
  assign w_stall   = (slv_req_i.aw_valid && !w_aw_ready) ||
                     (slv_req_i.ar_valid && !w_ar_ready);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_cnt    <= '0;
      r_ar_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_aw_cnt    <= r_aw_cnt    + StatsCntWidth'(w_aw_push);
      r_ar_cnt    <= r_ar_cnt    + StatsCntWidth'(w_ar_push);
      r_stall_cnt <= r_stall_cnt + StatsCntWidth'(w_stall);
    end
  end

  assign aw_cnt_o    = r_aw_cnt;
  assign ar_cnt_o    = r_ar_cnt;
  assign stall_cnt_o = r_stall_cnt;
`else
  assign aw_cnt_o    = '0;
  assign ar_cnt_o    = '0;
  assign stall_cnt_o = '0;
`endif

endmodule
